// File: rtl/rx_udp_mem_writer.sv
// rx_udp_mem_writer: captures one UDP payload frame byte-per-address into the RX SRAM and holds it until software releases it
// Ports: RX_CLK/RX_RST (async, active-high) clock and reset;
//   rx_udp_data_v/rx_udp_data payload byte stream; rx_frame_end/rx_frame_err frame
//   verdict pulses; rx_buf_release software release pulse;
//   mem_we/mem_addr/mem_wdata registered SRAM write port;
//   rx_ready/rx_len held-frame status; rx_drop_cnt saturating drop count;
//   rx_ovf sticky oversize flag.
module rx_udp_mem_writer #(
  parameter int OCT     = 8,
  parameter int ADDR_W  = 11,
  parameter int MAX_LEN = 1472
) (
  input  logic              RX_CLK,
  input  logic              RX_RST,
  input  logic              rx_udp_data_v,
  input  logic [OCT-1:0]    rx_udp_data,
  input  logic              rx_frame_end,
  input  logic              rx_frame_err,
  input  logic              rx_buf_release,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [OCT-1:0]    mem_wdata,
  output logic              rx_ready,
  output logic [15:0]       rx_len,
  output logic [15:0]       rx_drop_cnt,
  output logic              rx_ovf
);
  typedef enum logic [1:0] {IDLE, RECV, HOLD, DROP} state_t;
  localparam logic [ADDR_W:0] LP_MAX = (ADDR_W+1)'(MAX_LEN);
  state_t            r_state, w_state;
  logic [ADDR_W:0]   r_ptr, w_ptr, w_cnt;
  logic              r_we, r_ready, r_ovf, w_ready, w_ovf_flag;
  logic [ADDR_W-1:0] r_addr;
  logic [OCT-1:0]    r_wdata;
  logic [15:0]       r_len, r_drop, w_len;
  logic              w_free, w_active, w_ovf, w_wr, w_done, w_drop;
  // r_ptr is kept at 0 outside RECV, so a frame starting from IDLE or from a
  // same-cycle release in HOLD always writes its first byte at address 0.
  always_comb begin
    w_free     = (r_state == IDLE) || (r_state == HOLD && rx_buf_release);
    w_active   = (r_state == RECV) || (w_free && rx_udp_data_v);
    w_ovf      = w_active && rx_udp_data_v && r_ptr == LP_MAX;
    w_wr       = w_active && rx_udp_data_v && !w_ovf;
    w_cnt      = r_ptr + (ADDR_W+1)'(w_wr);
    w_done     = rx_frame_end || rx_frame_err;
    w_state    = r_state;
    w_ptr      = r_ptr;
    w_len      = r_len;
    w_ovf_flag = r_ovf;
    w_drop     = 1'b0;
    w_ready    = ((r_state == HOLD || r_state == DROP) && rx_buf_release) ? 1'b0 : r_ready;
    if (w_active) begin
      w_ptr = '0;
      if (w_ovf) begin
        w_ovf_flag = 1'b1;
        w_drop     = w_done;
        w_state    = w_done ? IDLE : DROP;
      end else if (rx_frame_err) begin
        w_drop  = 1'b1;
        w_state = IDLE;
      end else if (rx_frame_end) begin
        w_len      = 16'(w_cnt);
        w_ready    = 1'b1;
        w_ovf_flag = 1'b0;
        w_state    = HOLD;
      end else begin
        w_ptr   = w_cnt;
        w_state = RECV;
      end
    end else if (r_state == HOLD && rx_udp_data_v) begin
      // a one-byte frame that also ends this cycle is dropped without leaving HOLD
      w_drop  = w_done;
      w_state = w_done ? HOLD : DROP;
    end else if (r_state == HOLD && rx_buf_release) begin
      w_state = IDLE;
    end else if (r_state == DROP && w_done) begin
      w_drop  = 1'b1;
      w_state = w_ready ? HOLD : IDLE;
    end
  end
  always_ff @(posedge RX_CLK or posedge RX_RST) begin
    if (RX_RST) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ready <= 1'b0;
      r_len   <= '0;
      r_drop  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_we    <= w_wr;
      r_addr  <= r_ptr[ADDR_W-1:0];
      r_wdata <= rx_udp_data;
      r_ready <= w_ready;
      r_len   <= w_len;
      r_drop  <= r_drop + 16'(w_drop && r_drop != 16'hFFFF);
      r_ovf   <= w_ovf_flag;
    end
  end
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign rx_ready    = r_ready;
  assign rx_len      = r_len;
  assign rx_drop_cnt = r_drop;
  assign rx_ovf      = r_ovf;
endmodule

// File: tb/tb_rx_udp_mem_writer.sv
// tb_rx_udp_mem_writer: frame-level reference model bench for rx_udp_mem_writer
module tb_rx_udp_mem_writer;
  localparam int MAX_LEN = 1472;
  logic        RX_CLK = 0, RX_RST = 1, dv = 0, fe = 0, ferr = 0, rel = 0;
  logic [7:0]  d = 0;
  logic        mem_we, rx_ready, rx_ovf;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [15:0] rx_len, rx_drop_cnt;
  int          n_cmp = 0, n_bad = 0;
  logic [18:0] got_q[$], exp_q[$];
  logic        m_ready = 0, m_ovf = 0;
  logic [15:0] m_len = 0, m_drop = 0;
  rx_udp_mem_writer dut (
    .RX_CLK(RX_CLK), .RX_RST(RX_RST), .rx_udp_data_v(dv), .rx_udp_data(d),
    .rx_frame_end(fe), .rx_frame_err(ferr), .rx_buf_release(rel),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rx_ready(rx_ready), .rx_len(rx_len), .rx_drop_cnt(rx_drop_cnt), .rx_ovf(rx_ovf)
  );
  always #5 RX_CLK = ~RX_CLK;
  always @(negedge RX_CLK) if (mem_we === 1'b1) got_q.push_back({mem_addr, mem_wdata});
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge RX_CLK);
    #1;
  endtask
  task automatic check_frame(input string tag);
    chk({tag, "_nwr"}, got_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < got_q.size()) chk({tag, "_wr"}, got_q[i], exp_q[i]);
    chk({tag, "_ready"}, rx_ready, m_ready);
    chk({tag, "_len"}, rx_len, m_len);
    chk({tag, "_drop"}, rx_drop_cnt, m_drop);
    chk({tag, "_ovf"}, rx_ovf, m_ovf);
    got_q.delete();
    exp_q.delete();
  endtask
  // term: 0 = end, 1 = err, 2 = end and err together
  task automatic send(input string tag, input int len, input int term, input bit incr,
                      input bit rel1, input bit same);
    logic [7:0] b;
    bit free;
    free = !m_ready || rel1;
    for (int i = 0; i < len; i++) begin
      b = (rel1 && i == 0) ? 8'hAA : incr ? i[7:0] : 8'($urandom);
      if (free && i < MAX_LEN) exp_q.push_back({i[10:0], b});
      dv = 1; d = b; rel = rel1 && i == 0;
      if (same && i == len - 1) begin fe = term != 1; ferr = term != 0; end
      tick();
      if (rel && !fe) chk({tag, "_ready_at_release"}, rx_ready, 0);
      dv = 0; rel = 0; fe = 0; ferr = 0;
      if ($urandom_range(0, 3) == 0) tick();
    end
    if (!same) begin
      fe = term != 1; ferr = term != 0;
      tick();
      fe = 0; ferr = 0;
    end
    if (rel1) m_ready = 0;
    if (free && len <= MAX_LEN && term == 0) begin
      m_ready = 1; m_len = 16'(len); m_ovf = 0;
    end else begin
      if (m_drop != 16'hFFFF) m_drop++;
      if (free && len > MAX_LEN) m_ovf = 1;
    end
    tick(2);
    check_frame(tag);
  endtask
  task automatic release_buf();
    rel = 1;
    tick();
    rel = 0;
    m_ready = 0;
    tick();
    chk("release_ready", rx_ready, 0);
  endtask
  initial begin
    int len, term;
    tick(3);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    check_frame("rst");
    RX_RST = 0;
    tick();
    send("f64", 64, 0, 1, 0, 0);
    send("hold_drop", 10, 0, 0, 0, 0);
    release_buf();
    send("oversize", MAX_LEN + 1, 0, 0, 0, 0);
    send("end_err", 8, 2, 0, 0, 0);
    send("after_err", 5, 0, 0, 0, 0);
    send("rel_first", 6, 0, 0, 1, 0);
    release_buf();
    for (int k = 0; k < 24; k++) begin
      len  = ($urandom_range(0, 7) == 0) ? $urandom_range(MAX_LEN - 2, MAX_LEN + 3) : $urandom_range(1, 40);
      term = $urandom_range(0, 5);
      term = term < 4 ? 0 : term - 3;
      if (m_ready && $urandom_range(0, 2) == 0) release_buf();
      send("rand", len, term, 0, m_ready && $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
    end
    if (m_ready) release_buf();
    for (int i = 0; i < 5; i++) begin
      dv = 1; d = 8'(i + 16);
      tick();
    end
    dv = 0;
    chk("pre_rst_we", mem_we, 1);
    #2 RX_RST = 1;
    #1;
    chk("arst_we", mem_we, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_wdata", mem_wdata, 0);
    chk("arst_ready", rx_ready, 0);
    chk("arst_len", rx_len, 0);
    chk("arst_drop", rx_drop_cnt, 0);
    chk("arst_ovf", rx_ovf, 0);
    tick();
    RX_RST = 0;
    got_q.delete();
    exp_q.delete();
    m_ready = 0; m_ovf = 0; m_len = 0; m_drop = 0;
    tick();
    send("post_rst", 3, 0, 1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
